// File: rtl/rst_seq_sync_pkg.sv
// ---------------------------------------------------------------------------
// rst_seq_pkg
// Shared types and helpers for the reset synchroniser / sequencer.
//   seq_state_t : sequencer FSM states (also exported on seq_state for debug)
//   cnt_w()     : width of the shared hold/step counter
// ---------------------------------------------------------------------------
package rst_seq_pkg;

    typedef enum logic [1:0] {
        RESET   = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } seq_state_t;

    // Counter must hold values up to max(a,b); never narrower than one bit.
    function automatic int cnt_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        if (m < 1) begin
            return 1;
        end
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rst_seq_sync_chain.sv
// ---------------------------------------------------------------------------
// rst_sync_chain
// Asynchronous-assert / synchronous-release reset synchroniser.
// A chain of SYNC_STAGES flops with a constant 1 shifted in, all cleared
// asynchronously by RST_n.
// Ports:
//   RST_n      in  1  asynchronous active-low reset
//   clk        in  1  clock; active edge chosen by NEGEDGE
//   rst_sync_n out 1  synchronised reset, rises SYNC_STAGES edges after RST_n rises
// ---------------------------------------------------------------------------
module rst_sync_chain #(
    parameter int SYNC_STAGES = 2,
    parameter bit NEGEDGE     = 1'b1
) (
    input  logic RST_n,
    input  logic clk,
    output logic rst_sync_n
);

    // Clock polarity is fixed at elaboration, so this is a plain inverter
    // (or a wire) in the clock path.
    logic clk_act;
    assign clk_act = NEGEDGE ? ~clk : clk;

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift in ones; the shift form also works for a single-stage chain.
    always_ff @(posedge clk_act or negedge RST_n) begin
        if (!RST_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= (sync_q << 1) | SYNC_STAGES'(1);
        end
    end

    assign rst_sync_n = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq_sync.sv
// ---------------------------------------------------------------------------
// rst_seq_sync
// Reset synchroniser and sequencer for the Segway top level. Asserts NUM_CH
// downstream resets asynchronously from RST_n and releases them in order
// (ch0 first) after a hold period and a fixed stagger. soft_rst_req re-runs
// the sequence without touching RST_n.
// Ports:
//   clk          in  1       system clock (active edge chosen by NEGEDGE)
//   RST_n        in  1       pushbutton reset, asynchronous, active-low
//   soft_rst_req in  1       synchronous soft reset request
//   rst_n_out    out NUM_CH  sequenced active-low resets, bit k = channel k
//   all_rdy      out 1       every channel released
//   seq_state    out 2       FSM state (debug)
// ---------------------------------------------------------------------------
module rst_seq_sync
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_CH      = 3,
    parameter int HOLD_CYC    = 16,
    parameter int STEP_CYC    = 8,
    parameter bit NEGEDGE     = 1'b1
) (
    input  logic              clk,
    input  logic              RST_n,
    input  logic              soft_rst_req,
    output logic [NUM_CH-1:0] rst_n_out,
    output logic              all_rdy,
    output logic [1:0]        seq_state
);

    localparam int CNT_W = cnt_w(HOLD_CYC, STEP_CYC);
    localparam int IDX_W = $clog2(NUM_CH) + 1;

    logic clk_act;
    assign clk_act = NEGEDGE ? ~clk : clk;

    // The synchroniser instance is one stage short: the FSM leaving RESET is
    // the final stage. Decoding one edge early lets channel 0 be released on
    // exactly the edge the synchronised reset rises when HOLD_CYC is 0,
    // while every output still comes straight from a flop.
    logic sync_pre_n;

    rst_sync_chain #(
        .SYNC_STAGES (SYNC_STAGES - 1),
        .NEGEDGE     (NEGEDGE)
    ) u_sync (
        .RST_n      (RST_n),
        .clk        (clk),
        .rst_sync_n (sync_pre_n)
    );

    seq_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;

    // Hold ends after HOLD_CYC edges counted from the edge the synchronised
    // reset rose (or from the soft reset edge, with a minimum of one edge).
    logic hold_done;
    logic step_done;
    logic last_ch;
    logic first_release;

    always_comb begin
        hold_done     = (HOLD_CYC <= 1) || (int'(cnt) == HOLD_CYC - 1);
        step_done     = (int'(cnt) == STEP_CYC - 1);
        last_ch       = (int'(idx) == NUM_CH - 1);
        first_release = ((state == RESET) && sync_pre_n && (HOLD_CYC == 0)) ||
                        ((state == HOLD) && hold_done);
    end

    // Sequencer: counter, channel index and output register in one block so
    // every output is a flop and all of them clear together on RST_n.
    always_ff @(posedge clk_act or negedge RST_n) begin
        if (!RST_n) begin
            state     <= RESET;
            cnt       <= '0;
            idx       <= '0;
            rst_n_out <= '0;
            all_rdy   <= 1'b0;
        end else if (soft_rst_req && (state != RESET)) begin
            state     <= HOLD;
            cnt       <= '0;
            idx       <= '0;
            rst_n_out <= '0;
            all_rdy   <= 1'b0;
        end else if (first_release) begin
            rst_n_out <= NUM_CH'(1);
            cnt       <= '0;
            idx       <= IDX_W'(1);
            if (NUM_CH == 1) begin
                state   <= RUN;
                all_rdy <= 1'b1;
            end else begin
                state   <= RELEASE;
            end
        end else begin
            case (state)
                RESET: begin
                    if (sync_pre_n) begin
                        state <= HOLD;
                        cnt   <= '0;
                    end
                end
                HOLD: begin
                    cnt <= cnt + 1'b1;
                end
                RELEASE: begin
                    if (step_done) begin
                        // Channels release strictly in order, so shifting a
                        // one in from the bottom raises exactly channel idx.
                        rst_n_out <= (rst_n_out << 1) | NUM_CH'(1);
                        cnt       <= '0;
                        if (last_ch) begin
                            state   <= RUN;
                            all_rdy <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    assign seq_state = state;

endmodule

// File: tb/tb_rst_seq_sync.sv
// ---------------------------------------------------------------------------
// tb_rst_seq_sync
// Three instances share clk / RST_n / soft_rst_req:
//   d0: defaults (SYNC=2, NUM_CH=3, HOLD=16, STEP=8, falling edge)
//   d1: SYNC=3, NUM_CH=1, HOLD=0, STEP=1, falling edge
//   d2: defaults but rising edge
// The reference model tracks, per instance, the edge count since RST_n rose
// and the edge at which channel 0 is due; channel k is due STEP edges later
// per index.
// ---------------------------------------------------------------------------
module tb_rst_seq_sync;
    import rst_seq_pkg::*;

    logic clk = 1'b0;
    logic RST_n = 1'b1;
    logic soft_rst_req = 1'b0;

    logic [2:0] out0;
    logic       rdy0;
    logic [1:0] st0;
    logic [0:0] out1;
    logic       rdy1;
    logic [1:0] st1;
    logic [2:0] out2;
    logic       rdy2;
    logic [1:0] st2;

    rst_seq_sync u_dut0 (
        .clk(clk), .RST_n(RST_n), .soft_rst_req(soft_rst_req),
        .rst_n_out(out0), .all_rdy(rdy0), .seq_state(st0)
    );

    rst_seq_sync #(
        .SYNC_STAGES(3), .NUM_CH(1), .HOLD_CYC(0), .STEP_CYC(1), .NEGEDGE(1'b1)
    ) u_dut1 (
        .clk(clk), .RST_n(RST_n), .soft_rst_req(soft_rst_req),
        .rst_n_out(out1), .all_rdy(rdy1), .seq_state(st1)
    );

    rst_seq_sync #(
        .SYNC_STAGES(2), .NUM_CH(3), .HOLD_CYC(16), .STEP_CYC(8), .NEGEDGE(1'b0)
    ) u_dut2 (
        .clk(clk), .RST_n(RST_n), .soft_rst_req(soft_rst_req),
        .rst_n_out(out2), .all_rdy(rdy2), .seq_state(st2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        if (obs == exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state per instance.
    int p_s[3]  = '{2, 3, 2};
    int p_nc[3] = '{3, 1, 3};
    int p_h[3]  = '{16, 0, 16};
    int p_st[3] = '{8, 1, 8};
    int n_edge[3];
    int origin[3];

    task automatic modelReset();
        for (int d = 0; d < 3; d++) begin
            n_edge[d] = 0;
            origin[d] = p_s[d] + p_h[d];
        end
    endtask

    // Soft requests only count once the synchronised reset has been seen,
    // i.e. from edge SYNC+1 on.
    task automatic modelEdge(input int d);
        if (RST_n) begin
            n_edge[d]++;
            if (soft_rst_req && (n_edge[d] >= p_s[d] + 1)) begin
                origin[d] = n_edge[d] + ((p_h[d] > 1) ? p_h[d] : 1);
            end
        end
    endtask

    function automatic int expOut(input int d);
        int v;
        v = 0;
        if (RST_n) begin
            for (int k = 0; k < p_nc[d]; k++) begin
                if (n_edge[d] >= origin[d] + k * p_st[d]) begin
                    v = v | (1 << k);
                end
            end
        end
        return v;
    endfunction

    task automatic checkDut(input int d);
        int obs_out;
        int obs_rdy;
        int obs_st;
        int exp_out;
        int full;
        case (d)
            0:       begin obs_out = int'(out0); obs_rdy = int'(rdy0); obs_st = int'(st0); end
            1:       begin obs_out = int'(out1); obs_rdy = int'(rdy1); obs_st = int'(st1); end
            default: begin obs_out = int'(out2); obs_rdy = int'(rdy2); obs_st = int'(st2); end
        endcase
        exp_out = expOut(d);
        full    = (1 << p_nc[d]) - 1;
        checkOutput($sformatf("d%0d_rst_n_out", d), obs_out, exp_out);
        checkOutput($sformatf("d%0d_all_rdy", d), obs_rdy, int'(exp_out == full));
        if (!RST_n || n_edge[d] < p_s[d]) begin
            checkOutput($sformatf("d%0d_state_reset", d), obs_st, int'(RESET));
        end else if (exp_out == full) begin
            checkOutput($sformatf("d%0d_state_run", d), obs_st, int'(RUN));
        end else if (exp_out != 0) begin
            checkOutput($sformatf("d%0d_state_release", d), obs_st, int'(RELEASE));
        end else if (n_edge[d] > p_s[d]) begin
            checkOutput($sformatf("d%0d_state_hold", d), obs_st, int'(HOLD));
        end
    endtask

    // One clock period: drive the request, update and check the rising-edge
    // instance after the rising edge, then the falling-edge ones.
    task automatic applyStimulus(input logic req);
        soft_rst_req = req;
        @(posedge clk);
        modelEdge(2);
        #1;
        checkDut(2);
        @(negedge clk);
        modelEdge(0);
        modelEdge(1);
        #1;
        checkDut(0);
        checkDut(1);
    endtask

    // Called one time unit after a falling edge; the low pulse never overlaps
    // a clock edge when cycles is 0, so clearing must happen without a clock.
    task automatic applyReset(input int cycles);
        soft_rst_req = 1'b0;
        RST_n = 1'b0;
        modelReset();
        #1;
        for (int d = 0; d < 3; d++) begin
            checkDut(d);
        end
        repeat (cycles) applyStimulus(1'b0);
        #2;
        RST_n = 1'b1;
    endtask

    // Ordering and "rises only on an active edge" monitors.
    time last_edge[3];
    bit [2:0] prev0 = 3'b000;
    bit [0:0] prev1 = 1'b0;
    bit [2:0] prev2 = 3'b000;

    always @(negedge clk) begin
        last_edge[0] = $time;
        last_edge[1] = $time;
    end

    always @(posedge clk) begin
        last_edge[2] = $time;
    end

    function automatic int ordered3(input logic [2:0] v);
        return int'((!v[1] || v[0]) && (!v[2] || v[1]));
    endfunction

    always @(out0) begin
        if ((out0 & ~prev0) != 3'b000) begin
            checkOutput("d0_rise_on_edge", int'($time == last_edge[0]), 1);
        end
        checkOutput("d0_order", ordered3(out0), 1);
        prev0 = out0;
    end

    always @(out1) begin
        if ((out1 & ~prev1) != 1'b0) begin
            checkOutput("d1_rise_on_edge", int'($time == last_edge[1]), 1);
        end
        prev1 = out1;
    end

    always @(out2) begin
        if ((out2 & ~prev2) != 3'b000) begin
            checkOutput("d2_rise_on_edge", int'($time == last_edge[2]), 1);
        end
        checkOutput("d2_order", ordered3(out2), 1);
        prev2 = out2;
    end

    initial begin
        int r;
        modelReset();
        @(negedge clk);
        #1;

        $display("[TB] power-on reset, 5 cycles low");
        applyReset(5);
        // First edge after release is still RESET: the request is ignored.
        applyStimulus(1'b1);
        repeat (27) applyStimulus(1'b0);

        $display("[TB] short RST_n pulse during RELEASE");
        applyReset(0);
        repeat (40) applyStimulus(1'b0);

        $display("[TB] soft reset pulse in RUN");
        applyStimulus(1'b1);
        repeat (40) applyStimulus(1'b0);

        $display("[TB] soft reset during HOLD");
        applyReset(2);
        repeat (11) applyStimulus(1'b0);
        applyStimulus(1'b1);
        repeat (30) applyStimulus(1'b0);

        $display("[TB] soft reset held high");
        repeat (4) applyStimulus(1'b1);
        repeat (40) applyStimulus(1'b0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                applyReset(int'($urandom_range(0, 3)));
            end else if (r < 8) begin
                repeat ($urandom_range(1, 4)) applyStimulus(1'b1);
            end else begin
                applyStimulus(1'b0);
            end
        end
        repeat (40) applyStimulus(1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
